// File: rtl/intr_pkg.sv
// Shared constants and FSM encodings for the interrupt scheduler and its APB register block.
package intr_pkg;

  localparam int NUM_INTR_DEF = 16;
  localparam int PRIO_W_DEF   = 4;

  typedef enum logic [2:0] {
    S_NOINTR   = 3'b000,
    S_INTR_ACT = 3'b001,
    S_WAITING  = 3'b010
  } state_e;

endpackage

// File: rtl/intr_prio_enc.sv
// Combinational winner select: highest non-zero priority among pending sources, lowest index on ties.
module intr_prio_enc
  import intr_pkg::*;
#(
  parameter int NUM_INTR = NUM_INTR_DEF,
  parameter int WIDTH    = $clog2(NUM_INTR),
  parameter int PRIO_W   = PRIO_W_DEF
) (
  input  logic [NUM_INTR-1:0]        pend_i,
  input  logic [NUM_INTR*PRIO_W-1:0] prio_flat_i,
  output logic [WIDTH-1:0]           idx_o,
  output logic                       any_valid_o
);

  logic [PRIO_W-1:0] best_prio;

  // Starting the running best at zero excludes masked sources; strict '>' keeps the lowest index on ties.
  always_comb begin
    best_prio   = '0;
    idx_o       = '0;
    any_valid_o = 1'b0;
    for (int i = 0; i < NUM_INTR; i++) begin
      if (pend_i[i] && (prio_flat_i[i*PRIO_W +: PRIO_W] > best_prio)) begin
        best_prio   = prio_flat_i[i*PRIO_W +: PRIO_W];
        idx_o       = WIDTH'(i);
        any_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intr_prio_sched.sv
// Priority interrupt scheduler: sticky pending vector, priority arbitration, 4-phase service handshake.
// Optional service timeout built when INTR_TIMEOUT_EN is defined.
//
// state      | meaning
// S_NOINTR   | idle; arbitrates pending sources every cycle
// S_INTR_ACT | winner presented, waiting for intr_serviced_i=1
// S_WAITING  | serviced, waiting for intr_serviced_i to return to 0
module intr_prio_sched
  import intr_pkg::*;
#(
  parameter int NUM_INTR    = NUM_INTR_DEF,
  parameter int WIDTH       = $clog2(NUM_INTR),
  parameter int PRIO_W      = PRIO_W_DEF,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                       pclk_i,
  input  logic                       prst_ni,
  input  logic [NUM_INTR-1:0]        intr_active_i,
  input  logic [NUM_INTR*PRIO_W-1:0] prio_flat_i,
  input  logic                       intr_serviced_i,
  output logic [WIDTH-1:0]           intr_to_service_o,
  output logic                       intr_valid_o,
  output logic [NUM_INTR-1:0]        pend_o,
  output logic                       intr_timeout_o
);

  state_e              state_q, state_d;
  logic [NUM_INTR-1:0] pend_q, pend_d, clr_mask;
  logic [WIDTH-1:0]    idx_q, idx_d;
  logic                valid_q, valid_d;
  logic [WIDTH-1:0]    win_idx;
  logic                any_valid;
  logic                to_expire;

  intr_prio_enc #(
    .NUM_INTR (NUM_INTR),
    .WIDTH    (WIDTH),
    .PRIO_W   (PRIO_W)
  ) u_prio_enc (
    .pend_i      (pend_q),
    .prio_flat_i (prio_flat_i),
    .idx_o       (win_idx),
    .any_valid_o (any_valid)
  );

`ifdef INTR_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] to_cnt_q;
  logic             timeout_q;

  assign to_expire = (state_q == S_INTR_ACT) && (to_cnt_q == '0) && !intr_serviced_i;

  // Loaded on presentation so the terminal count lands exactly TIMEOUT_CYC edges later.
  always_ff @(posedge pclk_i or negedge prst_ni) begin
    if (!prst_ni) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= to_expire;
      if (state_q == S_NOINTR && any_valid) begin
        to_cnt_q <= CNT_W'(TIMEOUT_CYC - 1);
      end else if (state_q == S_INTR_ACT && to_cnt_q != '0) begin
        to_cnt_q <= to_cnt_q - 1'b1;
      end
    end
  end

  assign intr_timeout_o = timeout_q;
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = (TIMEOUT_CYC != 0);
  assign to_expire          = 1'b0;
  assign intr_timeout_o     = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    clr_mask = '0;
    case (state_q)
      S_NOINTR: begin
        if (any_valid) begin
          idx_d   = win_idx;
          valid_d = 1'b1;
          state_d = S_INTR_ACT;
        end
      end
      S_INTR_ACT: begin
        if (intr_serviced_i) begin
          clr_mask[idx_q] = 1'b1;
          valid_d         = 1'b0;
          state_d         = S_WAITING;
        end else if (to_expire) begin
          valid_d = 1'b0;
          state_d = S_NOINTR;
        end
      end
      S_WAITING: begin
        if (!intr_serviced_i) begin
          state_d = S_NOINTR;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = S_NOINTR;
      end
    endcase
  end

  // A new request on the clearing edge wins over the clear.
  assign pend_d = (pend_q & ~clr_mask) | intr_active_i;

  always_ff @(posedge pclk_i or negedge prst_ni) begin
    if (!prst_ni) begin
      state_q <= S_NOINTR;
      pend_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign intr_to_service_o = idx_q;
  assign intr_valid_o      = valid_q;
  assign pend_o            = pend_q;

endmodule
